// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, MDR, 16xN RAM, IR, A, B, ALU and OUT around one shared bus,
// steered by the 15-bit control word; a programming port loads RAM and freezes the core.
module sap1_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [14:0]       ctrl,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic [DATA_W-1:0] prog_rdata,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              carry,
  output logic              zero,
  output logic              bus_err
);
  localparam logic [14:0] IDLE = 15'h0FE3;

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d, ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic              cy_q, cy_d, z_q, z_d, err_q, err_d, ov_q, ov_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Programming mode swaps in the idle word, so every load and driver is off.
  logic [14:0] cw;
  assign cw = prog_en ? IDLE : ctrl;

  logic c_p, e_p, l_p, n_lma, n_lmd, n_ce, n_lr, n_li, n_ei, n_la, e_a, s_u, e_u, n_lb, n_lo;
  assign {c_p, e_p, l_p, n_lma, n_lmd, n_ce, n_lr, n_li, n_ei, n_la, e_a, s_u, e_u, n_lb, n_lo} = cw;

  logic [4:0] drv;
  logic       multi;
  assign drv   = {e_p, ~n_ei, ~n_ce, e_a, e_u};
  assign multi = |(drv & (drv - 5'd1));

  logic [DATA_W:0]   alu;
  logic [DATA_W-1:0] bus;
  assign alu = {1'b0, a_q} + {1'b0, (s_u ? ~b_q : b_q)} + {{DATA_W{1'b0}}, s_u};

  always_comb begin
    bus = '0;
    if (!multi) begin
      if (drv[4]) bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      if (drv[3]) bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
      if (drv[2]) bus = mem[mar_q];
      if (drv[1]) bus = a_q;
      if (drv[0]) bus = alu[DATA_W-1:0];
    end
  end

  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    ir_d  = ir_q;
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    cy_d  = cy_q;
    z_d   = z_q;
    err_d = err_q | multi;
    ov_d  = ~n_lo;
    if (l_p)      pc_d = bus[ADDR_W-1:0];
    else if (c_p) pc_d = pc_q + 1'b1;
    if (!n_lma) mar_d = bus[ADDR_W-1:0];
    if (!n_lmd) mdr_d = bus;
    if (!n_li)  ir_d  = bus;
    if (!n_la)  a_d   = bus;
    if (!n_lb)  b_d   = bus;
    if (!n_lo)  out_d = bus;
    // Flags track only ALU results written back into A.
    if (!n_la && e_u) begin
      cy_d = alu[DATA_W];
      z_d  = (alu[DATA_W-1:0] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      cy_q  <= 1'b0;
      z_q   <= 1'b0;
      err_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      cy_q  <= cy_d;
      z_q   <= z_d;
      err_q <= err_d;
      ov_q  <= ov_d;
    end
  end

  // RAM is not reset; programming writes stay live during reset, core writes do not.
  always_ff @(posedge clk) begin
    if (prog_en && prog_we)  mem[prog_addr] <= prog_wdata;
    else if (rst_n && !n_lr) mem[mar_q]     <= mdr_q;
  end

  assign prog_rdata = mem[prog_addr];
  assign opcode     = ir_q[DATA_W-1:DATA_W-4];
  assign out_data   = out_q;
  assign out_valid  = ov_q;
  assign carry      = cy_q;
  assign zero       = z_q;
  assign bus_err    = err_q;
endmodule

// File: tb/tb_sap1_datapath.sv
// Bench for sap1_datapath: directed micro-sequences plus random control words, all checked
// every cycle against a register-level behavioural model of the datapath.
module tb_sap1_datapath;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] ctrl;
  logic        prog_en, prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_wdata, prog_rdata, out_data;
  logic [3:0]  opcode;
  logic        out_valid, carry, zero, bus_err;

  always #5 clk = ~clk;

  sap1_datapath dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .prog_en(prog_en), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_rdata(prog_rdata),
    .opcode(opcode), .out_data(out_data), .out_valid(out_valid), .carry(carry),
    .zero(zero), .bus_err(bus_err)
  );

  localparam logic [14:0] IDLE = 15'h0FE3;
  localparam logic [14:0] CP = 15'h4000, EP = 15'h2000, LP = 15'h1000, LMA = 15'h0800,
                          LMD = 15'h0400, CE = 15'h0200, LR = 15'h0100, LI = 15'h0080,
                          EI = 15'h0040, LA = 15'h0020, EA = 15'h0010, SU = 15'h0008,
                          EU = 15'h0004, LB = 15'h0002, LO = 15'h0001;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  logic [3:0] m_pc, m_mar;
  logic [7:0] m_mdr, m_ir, m_a, m_b, m_out;
  logic       m_c, m_z, m_err, m_ov;
  logic [7:0] m_ram [16];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: one clock of the datapath, expressed as bus transfer then register moves.
  task automatic model(input logic [14:0] c, input logic pe, input logic we,
                       input logic [3:0] pa, input logic [7:0] pd, input logic rn);
    logic [7:0] bus, res;
    logic       cy;
    int         nd, s;
    nd = int'(c[13]) + int'(!c[6]) + int'(!c[9]) + int'(c[4]) + int'(c[2]);
    if (c[3]) begin res = m_a - m_b; cy = (m_a >= m_b); end
    else begin s = int'(m_a) + int'(m_b); res = 8'(s); cy = (s > 255); end
    bus = 8'h00;
    if (nd == 1) begin
      if (c[13])     bus = {4'h0, m_pc};
      else if (!c[6]) bus = {4'h0, m_ir[3:0]};
      else if (!c[9]) bus = m_ram[m_mar];
      else if (c[4])  bus = m_a;
      else            bus = res;
    end
    if (pe && we) m_ram[pa] = pd;
    else if (rn && !pe && !c[8]) m_ram[m_mar] = m_mdr;
    if (!rn) begin
      m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
      m_c = 0; m_z = 0; m_err = 0; m_ov = 0;
    end else if (pe) begin
      m_ov = 0;
    end else begin
      if (c[12])      m_pc = bus[3:0];
      else if (c[14]) m_pc = m_pc + 4'd1;
      if (!c[11]) m_mar = bus[3:0];
      if (!c[10]) m_mdr = bus;
      if (!c[7])  m_ir = bus;
      if (!c[5] && c[2]) begin m_c = cy; m_z = (res == 8'h00); end
      if (!c[5])  m_a = bus;
      if (!c[1])  m_b = bus;
      if (!c[0])  m_out = bus;
      m_ov = !c[0];
      if (nd > 1) m_err = 1;
    end
  endtask

  task automatic step(input logic [14:0] c, input logic pe, input logic we,
                      input logic [3:0] pa, input logic [7:0] pd, input logic rn);
    @(negedge clk); #1;
    ctrl = c; prog_en = pe; prog_we = we; prog_addr = pa; prog_wdata = pd; rst_n = rn;
    model(c, pe, we, pa, pd, rn);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [14:0] m);
    step(IDLE ^ m, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
  endtask

  task automatic pw(input logic [3:0] a, input logic [7:0] d);
    step(IDLE, 1'b1, 1'b1, a, d, 1'b1);
  endtask

  task automatic fetch();
    run(EP | LMA); run(CP); run(CE | LI);
  endtask

  // MAR is known from the model, so operands are staged through ram[MAR].
  task automatic ldreg(input logic [14:0] m, input logic [7:0] v);
    pw(m_mar, v); run(CE | m);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_data", out_data, m_out);
      chk("opcode", {4'h0, opcode}, {4'h0, m_ir[7:4]});
      chk("out_valid", {7'h0, out_valid}, {7'h0, m_ov});
      chk("carry", {7'h0, carry}, {7'h0, m_c});
      chk("zero", {7'h0, zero}, {7'h0, m_z});
      chk("bus_err", {7'h0, bus_err}, {7'h0, m_err});
      chk("prog_rdata", prog_rdata, m_ram[prog_addr]);
    end
  end

  initial begin
    logic [14:0] drvm [5];
    logic [14:0] rc;
    drvm = '{EP, EI, CE, EA, EU};
    rst_n = 0; ctrl = IDLE; prog_en = 0; prog_we = 0; prog_addr = 0; prog_wdata = 0;
    for (int i = 0; i < 16; i++) step(IDLE, 1'b1, 1'b1, 4'(i), 8'($urandom), 1'b0);
    chk_en = 1;

    // Reset with arbitrary control words; RAM must survive, prog_we without prog_en is inert.
    step(15'($urandom), 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    step(15'($urandom), 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    chk("rst_out", out_data, 8'h00);
    chk("rst_err", {7'h0, bus_err}, 8'h00);
    for (int i = 0; i < 16; i++) step(IDLE, 1'b0, 1'b1, 4'(i), 8'($urandom), 1'b1);

    // LDA 14 / ADD 15 / OUT / HLT
    pw(4'd0, 8'h4E); pw(4'd1, 8'h2F); pw(4'd2, 8'h50); pw(4'd3, 8'h00);
    pw(4'd14, 8'h05); pw(4'd15, 8'h03);
    fetch(); chk("lda_opcode", {4'h0, opcode}, 8'h04);
    run(EI | LMA); run(CE | LA);
    fetch(); run(EI | LMA); run(CE | LB); run(EU | LA);
    fetch(); run(EA | LO);
    chk("prog_out", out_data, 8'h08);
    chk("prog_ov", {7'h0, out_valid}, 8'h01);
    run(15'h0);
    chk("prog_ov_drop", {7'h0, out_valid}, 8'h00);
    fetch(); chk("hlt_opcode", {4'h0, opcode}, 8'h00);
    run(EP | LO); chk("hlt_pc", out_data, 8'h04);

    // SUB with and without borrow
    ldreg(LA, 8'h03); ldreg(LB, 8'h05); run(SU | EU | LA);
    chk("sub1_carry", {7'h0, carry}, 8'h00); chk("sub1_zero", {7'h0, zero}, 8'h00);
    run(EA | LO); chk("sub1_a", out_data, 8'hFE);
    ldreg(LA, 8'h05); ldreg(LB, 8'h05); run(SU | EU | LA);
    chk("sub2_carry", {7'h0, carry}, 8'h01); chk("sub2_zero", {7'h0, zero}, 8'h01);
    run(EA | LO); chk("sub2_a", out_data, 8'h00);

    // STA: A -> MDR -> ram[9]
    ldreg(LA, 8'hA5); pw(m_mar, 8'h09); run(CE | LMA);
    run(LMD | EA); run(LR);
    step(IDLE, 1'b1, 1'b0, 4'h9, 8'h00, 1'b1);
    chk("sta_ram9", prog_rdata, 8'hA5);

    // PC wrap and jump priority
    pw(m_mar, 8'h0F); run(CE | LP); run(EP | LO); chk("pc_f", out_data, 8'h0F);
    run(CP); run(EP | LO); chk("pc_wrap", out_data, 8'h00);
    pw(m_mar, 8'h07); run(CE | LP | CP); run(EP | LO); chk("pc_jmp", out_data, 8'h07);

    // Bus contention is sticky until reset
    run(EP | EA); chk("err_set", {7'h0, bus_err}, 8'h01);
    run(15'h0); run(15'h0); run(15'h0); chk("err_hold", {7'h0, bus_err}, 8'h01);
    step(IDLE, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0); chk("err_clr", {7'h0, bus_err}, 8'h00);

    for (int n = 0; n < 600; n++) begin
      int pick;
      rc = 15'h0;
      pick = $urandom_range(0, 5);
      if (pick < 5) rc |= drvm[pick];
      if ($urandom_range(0, 15) == 0) rc |= drvm[$urandom_range(0, 4)];
      rc |= (CP | LP | LMA | LMD | LR | LI | LA | SU | LB | LO) & 15'($urandom) & 15'($urandom);
      step(IDLE ^ rc, ($urandom_range(0, 7) == 0), 1'($urandom), 4'($urandom), 8'($urandom),
           ($urandom_range(0, 63) != 0));
    end
    step(IDLE, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
    @(negedge clk); #1;
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
